// File: rtl/frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : frame_sequencer
//  Purpose  : APU frame sequencer. A clock divider produces a terminal count
//             every STEP_CYCLES clocks. Each terminal count advances a 4- or
//             5-step sequence that emits quarter/half-frame pulses and an
//             optional frame interrupt.
//  Revision : 1.0 - initial release
// ============================================================================
module frame_sequencer #(
    parameter int CLKRATE   = 2_000_000,
    parameter int FRAMERATE = 240
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_we,
    input  logic [1:0] cfg_data,
    input  logic       irq_ack,
    output logic       quarter_frame,
    output logic       half_frame,
    output logic       irq,
    output logic [2:0] step,
    output logic       mode
);

    localparam int STEP_CYCLES = CLKRATE / FRAMERATE;
    localparam int DIV_W       = $clog2(STEP_CYCLES);
    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(STEP_CYCLES - 1);

    logic [DIV_W-1:0] r_div;
    logic [2:0]       r_step;
    logic             r_mode;
    logic             r_inhibit;
    logic             r_irq;
    logic             r_qf;
    logic             r_hf;

    logic             w_tc;
    logic [DIV_W-1:0] w_div_nxt;
    logic [2:0]       w_step_nxt;
    logic             w_q;
    logic             w_h;
    logic             w_irq_set;

    assign w_tc = (r_div == c_div_last);

    // Decode the divider wrap and the pulses/step advance owed at the end of
    // the current step; only meaningful when a terminal count occurs.
    always_comb begin
        w_div_nxt  = r_div + 1'b1;
        w_step_nxt = r_step;
        w_q        = 1'b0;
        w_h        = 1'b0;
        w_irq_set  = 1'b0;
        if (w_tc) begin
            w_div_nxt = '0;
            case (r_step)
                3'd0: w_q = 1'b1;
                3'd1: begin
                    w_q = 1'b1;
                    w_h = 1'b1;
                end
                3'd2: w_q = 1'b1;
                3'd3: begin
                    // Step 3 is silent in 5-step mode.
                    if (!r_mode) begin
                        w_q       = 1'b1;
                        w_h       = 1'b1;
                        w_irq_set = !r_inhibit;
                    end
                end
                3'd4: begin
                    w_q = 1'b1;
                    w_h = 1'b1;
                end
                default: begin
                    w_q = 1'b0;
                end
            endcase
            // Wrap on the last step of the active sequence length; the >=
            // keeps the step bounded even from an unexpected value.
            if (r_mode ? (r_step >= 3'd4) : (r_step >= 3'd3)) begin
                w_step_nxt = 3'd0;
            end else begin
                w_step_nxt = r_step + 3'd1;
            end
        end
    end

    // State register: reset beats a config write, which beats the terminal
    // count, so a write landing on a TC cycle restarts the sequence cleanly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div     <= '0;
            r_step    <= 3'd0;
            r_mode    <= 1'b0;
            r_inhibit <= 1'b0;
            r_irq     <= 1'b0;
            r_qf      <= 1'b0;
            r_hf      <= 1'b0;
        end else if (cfg_we) begin
            r_div     <= '0;
            r_step    <= 3'd0;
            r_mode    <= cfg_data[1];
            r_inhibit <= cfg_data[0];
            // Entering 5-step mode clocks the units once immediately.
            r_qf      <= cfg_data[1];
            r_hf      <= cfg_data[1];
            // Clearing inhibit leaves a pending interrupt untouched.
            if (cfg_data[0] || irq_ack) begin
                r_irq <= 1'b0;
            end
        end else begin
            r_div  <= w_div_nxt;
            r_step <= w_step_nxt;
            r_qf   <= w_q;
            r_hf   <= w_h;
            // A set on the same cycle as an acknowledge wins.
            if (w_irq_set) begin
                r_irq <= 1'b1;
            end else if (irq_ack) begin
                r_irq <= 1'b0;
            end
        end
    end

    assign quarter_frame = r_qf;
    assign half_frame    = r_hf;
    assign irq           = r_irq;
    assign step          = r_step;
    assign mode          = r_mode;

endmodule
`default_nettype wire
